md_unit: RTL

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// ----------------------------------------------------------------------------
// md_unit -- multicycle multiply/divide unit with HI/LO result registers.
//
// MULT/MULTU/DIV/DIVU latch their operands, hold busy for a fixed latency,
// then write {hi,lo} at the edge ending the last busy cycle. MTHI/MTLO write
// hi/lo directly when idle. flush aborts an in-flight operation without
// touching hi/lo.
//
// Configuration macro: MD_UNIT_DIV_EN
//   defined   -> DIV/DIVU supported
//   undefined -> no divider logic; op 2/3 are reported on op_invalid and ignored
// ----------------------------------------------------------------------------
module md_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             op_invalid
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // Counter holds "cycles remaining minus one"; sized for the longer latency.
    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
`ifdef MD_UNIT_DIV_EN
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               sgn_q, sgn_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [2*WIDTH-1:0] a_ext, b_ext, prod;

    assign busy = (state_q != S_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Flag unsupported opcodes while a request is presented.
    always_comb begin
        op_invalid = 1'b0;
        if (start) begin
`ifdef MD_UNIT_DIV_EN
            op_invalid = (op > OP_MTLO);
`else
            op_invalid = (op > OP_MTLO) || (op == OP_DIV) || (op == OP_DIVU);
`endif
        end
    end

    // Full-width product: sign-extend for MULT, zero-extend for MULTU.
    always_comb begin
        a_ext = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
        b_ext = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
        prod  = a_ext * b_ext;
    end

`ifdef MD_UNIT_DIV_EN
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs, q_u, r_u, q_res, r_res;

    // Magnitude divide, then restore signs: quotient truncates toward zero,
    // remainder takes the dividend's sign. MIN/-1 falls out as MIN rem 0.
    always_comb begin
        a_neg = sgn_q & a_q[WIDTH-1];
        b_neg = sgn_q & b_q[WIDTH-1];
        a_abs = a_neg ? (~a_q + 1'b1) : a_q;
        b_abs = b_neg ? (~b_q + 1'b1) : b_q;
        q_u   = '0;
        r_u   = '0;
        if (b_abs != '0) begin
            q_u = a_abs / b_abs;
            r_u = a_abs % b_abs;
        end
        q_res = (a_neg ^ b_neg) ? (~q_u + 1'b1) : q_u;
        r_res = a_neg ? (~r_u + 1'b1) : r_u;
        if (b_q == '0) begin
            q_res = '1;
            r_res = a_q;
        end
    end
`endif

    // Next-state logic: accept, countdown, result write-back, moves, flush.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                state_d = S_MUL;
                                cnt_d   = MUL_LOAD;
                                a_d     = num1;
                                b_d     = num2;
                                sgn_d   = (op == OP_MULT);
                            end
`ifdef MD_UNIT_DIV_EN
                            OP_DIV, OP_DIVU: begin
                                state_d = S_DIV;
                                cnt_d   = DIV_LOAD;
                                a_d     = num1;
                                b_d     = num2;
                                sgn_d   = (op == OP_DIV);
                            end
`endif
                            OP_MTHI: hi_d = num1;
                            OP_MTLO: lo_d = num1;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (cnt_q == '0) begin
                        {hi_d, lo_d} = prod;
                        state_d      = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
`ifdef MD_UNIT_DIV_EN
                S_DIV: begin
                    if (cnt_q == '0) begin
                        hi_d    = r_res;
                        lo_d    = q_res;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter, operand and HI/LO registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            // NOTE: operand latches are reset too; they are few flops and this keeps every state bit X-free.
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule
